// File: rtl/uart_rx_frame.sv
// UART frame receiver: start bit, LSB-first data, optional parity, one stop bit.
// Each bit is decided by a 3-sample majority vote around mid-bit at a latched prescale.
module uart_rx_frame #(
  parameter int dataWidth     = 8,
  parameter int prescaleWidth = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_in,
  input  logic [prescaleWidth-1:0] prescale,
  input  logic                     par_en,
  input  logic                     par_type,
  output logic [dataWidth-1:0]     p_data,
  output logic                     data_valid,
  output logic                     par_err,
  output logic                     stp_err
);

  localparam int BCW = (dataWidth > 1) ? $clog2(dataWidth) : 1;
  localparam logic [prescaleWidth-1:0] P_ONE    = 1;
  localparam logic [BCW-1:0]           BC_ONE   = 1;
  localparam logic [BCW-1:0]           LAST_BIT = BCW'(dataWidth - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [prescaleWidth-1:0] r_presc;
  logic [prescaleWidth-1:0] r_edge_cnt;
  logic                     r_par_en;
  logic                     r_par_type;
  logic                     r_par_err_int;
  logic [BCW-1:0]           r_bit_cnt;
  logic [2:0]               r_samp;
  logic [dataWidth-1:0]     r_shift;

  logic [prescaleWidth-1:0] w_presc_m1;
  logic [prescaleWidth-1:0] w_half;
  logic [prescaleWidth-1:0] w_half_m1;
  logic [prescaleWidth-1:0] w_half_p1;
  logic                     w_eval;
  logic                     w_bit;
  logic                     w_last;
  logic                     w_exp_par;
  logic                     w_frame_ok;

  assign w_presc_m1 = r_presc - P_ONE;
  assign w_half     = {1'b0, r_presc[prescaleWidth-1:1]};
  assign w_half_m1  = w_half - P_ONE;
  assign w_half_p1  = w_half + P_ONE;
  assign w_eval     = (r_edge_cnt == w_presc_m1);
  assign w_bit      = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
  assign w_last     = (r_bit_cnt == LAST_BIT);
  assign w_exp_par  = r_par_type ? ~^r_shift : ^r_shift;
  assign w_frame_ok = !r_par_err_int && w_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (!rx_in) w_next = START;
      START:   if (w_eval) w_next = w_bit ? IDLE : DATA;
      DATA:    if (w_eval && w_last) w_next = r_par_en ? PARITY : STOP;
      PARITY:  if (w_eval) w_next = STOP;
      STOP:    if (w_eval) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The start-detect edge is edge 0 of the start bit, so the counter resumes at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_edge_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_presc       <= '0;
      r_par_en      <= 1'b0;
      r_par_type    <= 1'b0;
      r_par_err_int <= 1'b0;
      p_data        <= '0;
      data_valid    <= 1'b0;
      par_err       <= 1'b0;
      stp_err       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (r_state == IDLE) begin
        r_bit_cnt <= '0;
        if (!rx_in) begin
          r_edge_cnt    <= P_ONE;
          r_presc       <= prescale;
          r_par_en      <= par_en;
          r_par_type    <= par_type;
          r_par_err_int <= 1'b0;
        end else begin
          r_edge_cnt <= '0;
        end
      end else begin
        r_edge_cnt <= w_eval ? '0 : r_edge_cnt + P_ONE;
        if (w_eval) begin
          unique case (r_state)
            DATA:   r_bit_cnt <= w_last ? '0 : r_bit_cnt + BC_ONE;
            PARITY: r_par_err_int <= (w_bit != w_exp_par);
            STOP: begin
              data_valid <= w_frame_ok;
              par_err    <= r_par_err_int;
              stp_err    <= !w_bit;
              if (w_frame_ok) p_data <= r_shift;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state != IDLE) begin
      if (r_edge_cnt == w_half_m1) r_samp[0] <= rx_in;
      if (r_edge_cnt == w_half)    r_samp[1] <= rx_in;
      if (r_edge_cnt == w_half_p1) r_samp[2] <= rx_in;
      if (r_state == DATA && w_eval) r_shift[r_bit_cnt] <= w_bit;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: drives serial frames and scores strobes against a frame-level model.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_type;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_frame #(.dataWidth(8), .prescaleWidth(6)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
    .par_en(par_en), .par_type(par_type), .p_data(p_data),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pd;
  } strobe_t;

  strobe_t    exp_q[$];
  strobe_t    act_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_double = 0;
  logic       prev_any = 1'b0;
  logic       any_now;
  logic [7:0] ref_pdata = 8'h00;

  always @(negedge clk) begin
    strobe_t r;
    any_now = data_valid | par_err | stp_err;
    if (any_now) begin
      r.cyc = cyc; r.dv = data_valid; r.pe = par_err; r.se = stp_err; r.pd = p_data;
      act_q.push_back(r);
    end
    if (any_now && prev_any) n_double++;
    prev_any = any_now;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_in = b;
    end
  endtask

  // Frame model: the line is N bit-times of p cycles; the verdict lands on the last cycle.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptype, input int p,
                            input logic pflip, input logic stop_b, input int noise_bit, input int gap);
    logic    bits[$];
    logic    v;
    logic    good_par;
    int      t0 = 0;
    int      mid;
    strobe_t e;
    good_par = ptype ? ~^d : ^d;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(good_par ^ pflip);
    bits.push_back(stop_b);
    mid = $urandom_range(0, 2);
    prescale = 6'(p); par_en = pen; par_type = ptype;
    for (int b = 0; b < bits.size(); b++) begin
      for (int i = 0; i < p; i++) begin
        @(negedge clk);
        if (b == 0 && i == 0) t0 = cyc + 1;
        if (b == 2 && i == 0) begin
          prescale = (p == 8) ? 6'd16 : 6'd8; par_en = ~pen; par_type = ~ptype;
        end
        v = bits[b];
        if (noise_bit >= 0 && b == noise_bit + 1 && i == p / 2 - 1 + mid) v = ~v;
        rx_in = v;
      end
    end
    e.cyc = t0 + bits.size() * p - 1;
    e.pe  = pen && pflip;
    e.se  = !stop_b;
    e.dv  = !e.pe && !e.se;
    if (e.dv) ref_pdata = d;
    e.pd  = ref_pdata;
    exp_q.push_back(e);
    hold(1'b1, gap);
  endtask

  initial begin
    int plist[3];
    int n;
    plist[0] = 8; plist[1] = 16; plist[2] = 32;
    rst = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_type = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_pdata", p_data, 0);
    check_eq("reset_strobes", {data_valid, par_err, stp_err}, 0);
    rst = 1'b1;
    hold(1'b1, 4);

    send_frame(8'hA5, 1'b1, 1'b0, 8, 1'b0, 1'b1, -1, 4);
    send_frame(8'h3C, 1'b1, 1'b1, 16, 1'b0, 1'b1, -1, 3);
    send_frame(8'h3C, 1'b1, 1'b1, 16, 1'b1, 1'b1, -1, 3);
    send_frame(8'hFF, 1'b0, 1'b0, 32, 1'b0, 1'b1, -1, 0);
    send_frame(8'h00, 1'b0, 1'b0, 32, 1'b0, 1'b1, -1, 5);
    send_frame(8'h55, 1'b0, 1'b0, 16, 1'b0, 1'b0, -1, 3);
    send_frame(8'h96, 1'b1, 1'b0, 8, 1'b1, 1'b0, -1, 3);

    prescale = 6'd8;
    hold(1'b0, 2);
    hold(1'b1, 6);
    send_frame(8'hC3, 1'b1, 1'b0, 8, 1'b0, 1'b1, -1, 2);
    send_frame(8'h5A, 1'b1, 1'b1, 16, 1'b0, 1'b1, 3, 2);

    prescale = 6'd16; par_en = 1'b1; par_type = 1'b0;
    hold(1'b0, 16);
    for (int i = 0; i < 4; i++) hold((8'h81 >> i) & 1, 16);
    hold(1'b0, 8);
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_pdata", p_data, 0);
    check_eq("midrst_strobes", {data_valid, par_err, stp_err}, 0);
    ref_pdata = 8'h00;
    rx_in = 1'b1;
    hold(1'b1, 3);
    rst = 1'b1;
    hold(1'b1, 5);
    send_frame(8'h81, 1'b1, 1'b0, 16, 1'b0, 1'b1, -1, 3);

    for (int k = 0; k < 24; k++) begin
      logic pen;
      pen = 1'($urandom_range(0, 1));
      send_frame(8'($urandom_range(0, 255)), pen, 1'($urandom_range(0, 1)),
                 plist[$urandom_range(0, 2)], pen && ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 4) != 0,
                 ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1,
                 $urandom_range(0, 3));
    end
    hold(1'b1, 20);

    check_eq("n_strobes", act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("cyc[%0d]", i), act_q[i].cyc, exp_q[i].cyc);
      check_eq($sformatf("dv[%0d]", i),  act_q[i].dv,  exp_q[i].dv);
      check_eq($sformatf("pe[%0d]", i),  act_q[i].pe,  exp_q[i].pe);
      check_eq($sformatf("se[%0d]", i),  act_q[i].se,  exp_q[i].se);
      check_eq($sformatf("pd[%0d]", i),  act_q[i].pd,  exp_q[i].pd);
    end
    check_eq("no_double_strobe", n_double, 0);
    check_eq("final_pdata", p_data, ref_pdata);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
